// File: rtl/core_pkg.sv
// Shared core definitions: default datapath sizes and common scalar types
// used by the register file and its scoreboard.
package core_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for long-latency ops: issue sets, retiring
// writeback clears, and busy source operands are reported to the hazard unit.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0]     raddr,
    input  logic [NWR-1:0]                        wr_en,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0]     waddr,
    input  logic [NWR-1:0]                        wr_clr,
    input  logic                                  iss_en,
    input  logic [$clog2(NREGS)-1:0]              iss_addr,
    output logic [NRD-1:0]                        rbusy,
    output logic [NREGS-1:0]                      busy_vec
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    // Register 0 is excluded from both masks so it can never become busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 1; i < NREGS; i++) begin
            set_vec[i] = iss_en && (iss_addr == AW'(i));
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_clr[w] && (waddr[w] == AW'(i))) begin
                    clr_vec[i] = 1'b1;
                end
            end
        end
    end

    // Set overrides clear so a back-to-back reissue keeps the register busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= set_vec | (busy & ~clr_vec);
        end
    end

    // A retiring write is forwarded by the bypass, so it releases the stall early.
    always_comb begin
        rbusy = '0;
        for (int r = 0; r < NRD; r++) begin
            if (raddr[r] != '0) begin
                rbusy[r] = busy[raddr[r]] && ((BYPASS == 0) ? 1'b1 : !clr_vec[raddr[r]]);
            end
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired-zero x0, same-cycle
// write-to-read bypass and an attached busy scoreboard.
module regfile_mp_sb
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0]     raddr,
    output logic [NRD-1:0][XLEN-1:0]              rdata,
    output logic [NRD-1:0]                        rbusy,
    input  logic [NWR-1:0]                        wr_en,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0]     waddr,
    input  logic [NWR-1:0][XLEN-1:0]              wdata,
    input  logic [NWR-1:0]                        wr_clr,
    input  logic                                  iss_en,
    input  logic [$clog2(NREGS)-1:0]              iss_addr,
    output logic [NREGS-1:0]                      busy_vec
);

    logic [XLEN-1:0] regs [NREGS];

    // Ports are applied in ascending order so the highest-index port wins a conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (waddr[w] != '0)) begin
                    regs[waddr[w]] <= wdata[w];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rdata[r] = (raddr[r] == '0) ? '0 : regs[raddr[r]];
            if ((BYPASS != 0) && (raddr[r] != '0)) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (waddr[w] == raddr[r])) begin
                        rdata[r] = wdata[w];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .wr_en    (wr_en),
        .waddr    (waddr),
        .wr_clr   (wr_clr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rbusy    (rbusy),
        .busy_vec (busy_vec)
    );

endmodule
